// File: rtl/i2c_target_regfile_pkg.sv
// i2c_target_regfile_pkg
// Shared definitions for the I2C target register file: FSM state encoding,
// ACK/NACK bus levels and a small helper that groups the three ACK states.
package i2c_target_regfile_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_A_ACK,
    ST_PTR,
    ST_P_ACK,
    ST_WR,
    ST_W_ACK,
    ST_RD,
    ST_R_ACK
  } state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Address, pointer and write-data ACKs all follow the same two-fall sequence.
  function automatic logic isAckState(state_e s);
    return (s == ST_A_ACK) || (s == ST_P_ACK) || (s == ST_W_ACK);
  endfunction

endpackage

// File: rtl/i2c_target_regfile_bus_sync.sv
// i2c_bus_sync
// Synchronises the raw scl/sda bus levels into the clk domain and derives
// single-cycle event strobes from the synchronised values.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   scl_i, sda_i        raw bus levels
//   scl_o, sda_o        synchronised levels (reset value 1 = idle bus)
//   sclRise_o/sclFall_o one-cycle scl edge strobes
//   start_o/stop_o      one-cycle START / STOP strobes
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic sclRise_o,
  output logic sclFall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] sclChain_q;
  logic [SYNC_STAGES-1:0] sdaChain_q;
  logic                   sclPrev_q;
  logic                   sdaPrev_q;

  // Flop chains reset to 1 so an idle bus never looks like an edge after reset;
  // the extra "prev" flops hold last cycle's synchronised level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclChain_q <= '1;
      sdaChain_q <= '1;
      sclPrev_q  <= 1'b1;
      sdaPrev_q  <= 1'b1;
    end else begin
      sclChain_q <= {sclChain_q[SYNC_STAGES-2:0], scl_i};
      sdaChain_q <= {sdaChain_q[SYNC_STAGES-2:0], sda_i};
      sclPrev_q  <= sclChain_q[SYNC_STAGES-1];
      sdaPrev_q  <= sdaChain_q[SYNC_STAGES-1];
    end
  end

  assign scl_o     = sclChain_q[SYNC_STAGES-1];
  assign sda_o     = sdaChain_q[SYNC_STAGES-1];
  assign sclRise_o = scl_o & ~sclPrev_q;
  assign sclFall_o = ~scl_o & sclPrev_q;
  // SDA may only move while SCL is steadily high for START/STOP.
  assign start_o   = scl_o & sclPrev_q & sdaPrev_q & ~sda_o;
  assign stop_o    = scl_o & sclPrev_q & ~sdaPrev_q & sda_o;

endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile
// I2C target for 7-bit addressing: matches SLAVE_ADDR, takes a register
// pointer byte followed by write data, and serves reads from a local register
// file. SDA is open-drain (sda_o is tied low, sda_oen releases); SCL is input only.
// Ports:
//   clk, rst                      system clock, asynchronous active-high reset
//   scl_i, sda_i                  bus levels
//   sda_o, sda_oen                SDA drive value (0) and release control (1 = released)
//   loc_we, loc_addr, loc_wdata   local write port
//   loc_rdata                     regs[loc_addr], combinational
//   wr_pulse, wr_addr, wr_data    one-cycle report of each bus write commit
//   busy                          address matched, transfer in progress
module i2c_target_regfile
  import i2c_target_regfile_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h10,
  parameter int         NUM_REGS    = 8,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_o,
  output logic          sda_oen,
  input  logic          loc_we,
  input  logic [PW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  output logic [7:0]    loc_rdata,
  output logic          wr_pulse,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  logic sclS, sdaS, sclRise, sclFall, startDet, stopDet;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_o     (sclS),
    .sda_o     (sdaS),
    .sclRise_o (sclRise),
    .sclFall_o (sclFall),
    .start_o   (startDet),
    .stop_o    (stopDet)
  );

  state_e        state_q, state_d;
  logic          phase_q, phase_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rdShift_q, rdShift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          sdaOen_q, sdaOen_d;
  logic          busy_q, busy_d;
  logic          wrPulse_q, wrPulse_d;
  logic [PW-1:0] wrAddr_q, wrAddr_d;
  logic [7:0]    wrData_q, wrData_d;
  logic [7:0]    regs_q [NUM_REGS];

  logic [7:0]    byteIn;
  logic [7:0]    rdByte;

  assign byteIn = {shift_q[6:0], sdaS};
  assign rdByte = regs_q[ptr_q];

  // Protocol state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      bitCnt_q  <= 3'd0;
      shift_q   <= 8'h00;
      rdShift_q <= 8'h00;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sdaOen_q  <= 1'b1;
      busy_q    <= 1'b0;
      wrPulse_q <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      rdShift_q <= rdShift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sdaOen_q  <= sdaOen_d;
      busy_q    <= busy_d;
      wrPulse_q <= wrPulse_d;
      wrAddr_q  <= wrAddr_d;
      wrData_q  <= wrData_d;
    end
  end

  // Next-state logic. START/STOP override everything so an SDA edge while SCL
  // is high is never taken as data. ACK states use phase: the first SCL fall
  // starts pulling SDA low, the second ends the ACK clock. Read bytes are
  // captured from the register file at the moment RD is entered.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    rdShift_d = rdShift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sdaOen_d  = sdaOen_q;
    busy_d    = busy_q;
    wrPulse_d = 1'b0;
    wrAddr_d  = wrAddr_q;
    wrData_d  = wrData_q;

    if (stopDet) begin
      state_d  = ST_IDLE;
      sdaOen_d = 1'b1;
      busy_d   = 1'b0;
    end else if (startDet) begin
      state_d  = ST_ADDR;
      bitCnt_d = 3'd0;
      phase_d  = 1'b0;
      sdaOen_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sdaOen_d = 1'b1;
          busy_d   = 1'b0;
        end
        ST_ADDR: begin
          if (sclRise) begin
            shift_d  = byteIn;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              if (byteIn[7:1] == SLAVE_ADDR) begin
                state_d = ST_A_ACK;
                rw_d    = byteIn[0];
                busy_d  = 1'b1;
                phase_d = 1'b0;
              end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        ST_A_ACK, ST_P_ACK, ST_W_ACK: begin
          if (sclFall) begin
            if (!phase_q) begin
              sdaOen_d = I2C_ACK;
              phase_d  = 1'b1;
            end else begin
              phase_d  = 1'b0;
              bitCnt_d = 3'd0;
              sdaOen_d = 1'b1;
              if (state_q == ST_A_ACK && rw_q) begin
                state_d   = ST_RD;
                sdaOen_d  = rdByte[7];
                rdShift_d = {rdByte[6:0], 1'b0};
              end else if (state_q == ST_A_ACK) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WR;
              end
            end
          end
        end
        ST_PTR: begin
          if (sclRise) begin
            shift_d  = byteIn;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              ptr_d   = byteIn[PW-1:0];
              state_d = ST_P_ACK;
              phase_d = 1'b0;
            end
          end
        end
        ST_WR: begin
          if (sclRise) begin
            shift_d  = byteIn;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              wrPulse_d = 1'b1;
              wrAddr_d  = ptr_q;
              wrData_d  = byteIn;
              ptr_d     = ptr_q + PW'(1);
              state_d   = ST_W_ACK;
              phase_d   = 1'b0;
            end
          end
        end
        ST_RD: begin
          if (sclFall) begin
            if (bitCnt_q == 3'd7) begin
              sdaOen_d = 1'b1;
              state_d  = ST_R_ACK;
              phase_d  = 1'b0;
            end else begin
              sdaOen_d  = rdShift_q[7];
              rdShift_d = {rdShift_q[6:0], 1'b0};
              bitCnt_d  = bitCnt_q + 3'd1;
            end
          end
        end
        ST_R_ACK: begin
          if (!phase_q) begin
            if (sclRise) begin
              if (sdaS == I2C_ACK) begin
                ptr_d   = ptr_q + PW'(1);
                phase_d = 1'b1;
              end else begin
                state_d  = ST_IDLE;
                sdaOen_d = 1'b1;
                busy_d   = 1'b0;
              end
            end
          end else if (sclFall) begin
            state_d   = ST_RD;
            phase_d   = 1'b0;
            bitCnt_d  = 3'd0;
            sdaOen_d  = rdByte[7];
            rdShift_d = {rdByte[6:0], 1'b0};
          end
        end
        default: begin
          state_d  = ST_IDLE;
          sdaOen_d = 1'b1;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // Register file. The bus commit is applied after the local write so that a
  // same-register collision resolves in favour of the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      if (loc_we) regs_q[loc_addr] <= loc_wdata;
      if (wrPulse_d) regs_q[wrAddr_d] <= wrData_d;
    end
  end

  assign sda_o     = 1'b0;
  assign sda_oen   = sdaOen_q;
  assign busy      = busy_q;
  assign wr_pulse  = wrPulse_q;
  assign wr_addr   = wrAddr_q;
  assign wr_data   = wrData_q;
  assign loc_rdata = regs_q[loc_addr];

endmodule
